// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared constants and types for the register scoreboard slice.
//   ADDR_W     register address width
//   NUM_REGS   number of tracked architectural registers (R0..R14)
//   CNT_W      width of each per-register in-flight write counter
//   PC_ADDR    address of the untracked program counter
package reg_scoreboard_pkg;

  localparam int ADDR_W     = 4;
  localparam int NUM_REGS   = 15;
  localparam int CNT_W      = 2;
  localparam int ADDR_SPACE = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_addr_t PC_ADDR = 4'd15;
  localparam cnt_t      CNT_MAX = '1;

  // True for addresses that have a counter behind them; everything at or
  // above NUM_REGS (the PC) is never hazard-tracked.
  function automatic logic isTracked(reg_addr_t addr);
    return int'(addr) < NUM_REGS;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if
// Bundles the ID-stage issue request, the WB-stage write-back notification
// and the scoreboard's hazard/status outputs.
//   master : ID/WB side, drives issue_* / src* / flush / wb_*, reads status
//   slave  : scoreboard side, reads requests, drives stall, issue_fire,
//            pending_mask, busy, err
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                issue_valid;
  logic                issue_wb_en;
  reg_addr_t           issue_dest;
  reg_addr_t           src1;
  reg_addr_t           src2;
  logic                src2_used;
  logic                flush;
  logic                wb_en;
  reg_addr_t           wb_dest;
  logic                stall;
  logic                issue_fire;
  logic [NUM_REGS-1:0] pending_mask;
  logic                busy;
  logic                err;

  modport master (
    output issue_valid, issue_wb_en, issue_dest, src1, src2, src2_used,
           flush, wb_en, wb_dest,
    input  stall, issue_fire, pending_mask, busy, err
  );

  modport slave (
    input  issue_valid, issue_wb_en, issue_dest, src1, src2, src2_used,
           flush, wb_en, wb_dest,
    output stall, issue_fire, pending_mask, busy, err
  );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// sb_counter
// One per-register in-flight write counter.
//   clk, rst     pipeline clock, asynchronous active-high reset
//   inc_i        an accepted instruction allocates this register
//   dec_i        write-back to this register this cycle
//   cnt_o        current count (registered)
//   cntNext_o    count after the coming rising edge
//   underflow_o  write-back seen while the count is already zero
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output cnt_t cnt_o,
  output cnt_t cntNext_o,
  output logic underflow_o
);

  cnt_t cnt_q;
  cnt_t cnt_d;

  // Simultaneous allocate and retire cancel out. A lone retire on an empty
  // counter is an underflow and holds at zero; the hazard logic never lets
  // an allocate hit a full counter, the guard just keeps it from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + cnt_t'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign cntNext_o   = cnt_d;
  assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Issue-side hazard controller for R0..R14. Counts in-flight writes per
// destination between ID issue and WB write-back and stalls issue on RAW,
// WAW and counter saturation. Same-cycle write-back is bypassed because the
// register file writes on the falling edge.
//   clk, rst  pipeline clock, asynchronous active-high reset
//   sb        slave side of reg_scoreboard_if:
//             stall/issue_fire combinational, pending_mask/busy/err registered
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  reg_scoreboard_if.slave   sb
);

  logic [NUM_REGS-1:0]   wbHit;
  logic [NUM_REGS-1:0]   incHit;
  logic [NUM_REGS-1:0]   effNz;
  logic [NUM_REGS-1:0]   satBlock;
  logic [NUM_REGS-1:0]   underflow;
  logic [NUM_REGS-1:0]   pendingMask_d;
  logic [NUM_REGS-1:0]   pendingMask_q;
  logic [ADDR_SPACE-1:0] effNzAll;
  logic [ADDR_SPACE-1:0] satAll;
  cnt_t                  cnt     [NUM_REGS];
  cnt_t                  cntNext [NUM_REGS];
  logic                  raw1;
  logic                  raw2;
  logic                  waw;
  logic                  sat;
  logic                  stall;
  logic                  issueFire;
  logic                  busy_d;
  logic                  busy_q;
  logic                  err_d;
  logic                  err_q;

  // One counter per tracked register. The effective count seen by ID is the
  // count minus a same-cycle write-back, clamped at zero, so "still pending"
  // is simply cnt > wbHit. A full counter only blocks a new writer when no
  // write-back frees a slot this cycle.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign wbHit[r]  = sb.wb_en && (sb.wb_dest == reg_addr_t'(r));
    assign incHit[r] = issueFire && sb.issue_wb_en &&
                       (sb.issue_dest == reg_addr_t'(r));

    sb_counter u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (incHit[r]),
      .dec_i       (wbHit[r]),
      .cnt_o       (cnt[r]),
      .cntNext_o   (cntNext[r]),
      .underflow_o (underflow[r])
    );

    assign effNz[r]         = cnt[r] > cnt_t'(wbHit[r]);
    assign satBlock[r]      = (cnt[r] == CNT_MAX) && !wbHit[r];
    assign pendingMask_d[r] = cntNext[r] != '0;
  end

  // Zero-extend to the full address space so untracked addresses (the PC)
  // index a constant zero and can never raise a hazard.
  assign effNzAll = ADDR_SPACE'(effNz);
  assign satAll   = ADDR_SPACE'(satBlock);

  // Hazard detection; flush squashes the instruction, so it neither stalls
  // nor allocates.
  always_comb begin
    raw1      = 1'b0;
    raw2      = 1'b0;
    waw       = 1'b0;
    sat       = 1'b0;
    stall     = 1'b0;
    issueFire = 1'b0;
    if (sb.issue_valid) begin
      raw1 = effNzAll[sb.src1];
      raw2 = sb.src2_used && effNzAll[sb.src2];
      waw  = sb.issue_wb_en && effNzAll[sb.issue_dest];
      sat  = sb.issue_wb_en && isTracked(sb.issue_dest) &&
             satAll[sb.issue_dest];
    end
    stall     = sb.issue_valid && !sb.flush && (raw1 || raw2 || waw || sat);
    issueFire = sb.issue_valid && !sb.flush && !stall;
  end

  // Status flags track the post-edge counts; err latches any underflow.
  always_comb begin
    busy_d = |pendingMask_d;
    err_d  = err_q || (|underflow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendingMask_q <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      pendingMask_q <= pendingMask_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign sb.stall        = stall;
  assign sb.issue_fire   = issueFire;
  assign sb.pending_mask = pendingMask_q;
  assign sb.busy         = busy_q;
  assign sb.err          = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
// Self-checking bench for reg_scoreboard: directed scenarios followed by a
// randomized run, all checked against a behavioural per-register count model.
module tb_reg_scoreboard;

  localparam int NREG = 15;
  localparam int MAXC = 3;

  logic clk;
  logic rst;

  reg_scoreboard_if sbIf ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model: number of outstanding writes per register.
  int mCnt [NREG];
  bit mErr;
  bit expStall;
  bit expFire;

  function automatic void modelReset();
    for (int r = 0; r < NREG; r++) mCnt[r] = 0;
    mErr = 1'b0;
  endfunction

  function automatic logic [NREG-1:0] expMask();
    logic [NREG-1:0] m;
    m = '0;
    for (int r = 0; r < NREG; r++) m[r] = (mCnt[r] != 0);
    return m;
  endfunction

  function automatic int wbHitOf(int a);
    return (sbIf.wb_en && int'(sbIf.wb_dest) == a && a < NREG) ? 1 : 0;
  endfunction

  function automatic int effOf(int a);
    int e;
    if (a >= NREG) return 0;
    e = mCnt[a] - wbHitOf(a);
    return (e < 0) ? 0 : e;
  endfunction

  // Drive one cycle's inputs and derive the expected combinational outputs.
  task automatic applyStimulus(input bit v, input bit iwb, input int dest,
                               input int s1, input int s2, input bit s2u,
                               input bit fl, input bit we, input int wd);
    bit hz;
    int d;
    sbIf.issue_valid = v;
    sbIf.issue_wb_en = iwb;
    sbIf.issue_dest  = 4'(dest);
    sbIf.src1        = 4'(s1);
    sbIf.src2        = 4'(s2);
    sbIf.src2_used   = s2u;
    sbIf.flush       = fl;
    sbIf.wb_en       = we;
    sbIf.wb_dest     = 4'(wd);
    #1;
    d  = int'(sbIf.issue_dest);
    hz = (effOf(int'(sbIf.src1)) != 0) ||
         (s2u && effOf(int'(sbIf.src2)) != 0) ||
         (iwb && effOf(d) != 0) ||
         (iwb && d < NREG && mCnt[d] == MAXC && wbHitOf(d) == 0);
    expStall = v && !fl && hz;
    expFire  = v && !fl && !expStall;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one rising edge and move the model forward with the same inputs.
  task automatic clockEdge();
    int n;
    int hit;
    int incr;
    @(posedge clk);
    for (int r = 0; r < NREG; r++) begin
      hit  = wbHitOf(r);
      incr = (expFire && sbIf.issue_wb_en && int'(sbIf.issue_dest) == r) ? 1 : 0;
      if (hit == 1 && mCnt[r] == 0) mErr = 1'b1;
      n = mCnt[r] + incr - hit;
      if (n < 0) n = 0;
      if (n > MAXC) n = MAXC;
      mCnt[r] = n;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1;
    assertCount++;
    if (sbIf.stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_stall: got %0b expected 0", sbIf.stall);
    end
    assertCount++;
    if (sbIf.pending_mask !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_mask: got %h expected 0", sbIf.pending_mask);
    end
    assertCount++;
    if (sbIf.busy !== 1'b0 || sbIf.err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got busy=%0b err=%0b expected 0/0",
               sbIf.busy, sbIf.err);
    end
    rst = 1'b0;
    modelReset();
    clockEdge();
  endtask

  task automatic test_raw();
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0);
    assertCount++;
    if (sbIf.issue_fire !== 1'b1 || expFire !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL raw_producer_fire: got %0b expected 1", sbIf.issue_fire);
    end
    clockEdge();
    assertCount++;
    if (sbIf.pending_mask !== 15'h0008) begin
      failCount++;
      $display("[TB] FAIL raw_mask_set: got %h expected 0008", sbIf.pending_mask);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 3, 0, 0, 0, 0, 0);
      assertCount++;
      if (sbIf.stall !== 1'b1 || sbIf.issue_fire !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL raw_hold: got stall=%0b fire=%0b expected 1/0",
                 sbIf.stall, sbIf.issue_fire);
      end
      clockEdge();
    end
    applyStimulus(1, 0, 0, 3, 0, 0, 0, 1, 3);
    assertCount++;
    if (sbIf.stall !== 1'b0 || sbIf.issue_fire !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL raw_bypass: got stall=%0b fire=%0b expected 0/1",
               sbIf.stall, sbIf.issue_fire);
    end
    clockEdge();
    assertCount++;
    if (sbIf.pending_mask !== 15'h0000 || sbIf.busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL raw_drain: got mask=%h busy=%0b expected 0000/0",
               sbIf.pending_mask, sbIf.busy);
    end
  endtask

  task automatic test_same_cycle();
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 1, 5);
    assertCount++;
    if (sbIf.issue_fire !== 1'b1 || sbIf.stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL same_cycle_fire: got fire=%0b stall=%0b expected 1/0",
               sbIf.issue_fire, sbIf.stall);
    end
    clockEdge();
    assertCount++;
    if (sbIf.pending_mask !== 15'h0020 || mCnt[5] != 1) begin
      failCount++;
      $display("[TB] FAIL same_cycle_mask: got %h expected 0020", sbIf.pending_mask);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5);
    clockEdge();
  endtask

  task automatic test_flush();
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0);
    clockEdge();
    applyStimulus(1, 1, 9, 0, 2, 1, 1, 0, 0);
    assertCount++;
    if (sbIf.stall !== 1'b0 || sbIf.issue_fire !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL flush_over_hazard: got stall=%0b fire=%0b expected 0/0",
               sbIf.stall, sbIf.issue_fire);
    end
    clockEdge();
    assertCount++;
    if (sbIf.pending_mask !== 15'h0004) begin
      failCount++;
      $display("[TB] FAIL flush_no_alloc: got %h expected 0004", sbIf.pending_mask);
    end
    applyStimulus(1, 0, 0, 0, 2, 1, 0, 0, 0);
    assertCount++;
    if (sbIf.stall !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL flush_src2_raw: got %0b expected 1", sbIf.stall);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2);
    clockEdge();
  endtask

  task automatic test_pc();
    applyStimulus(1, 1, 15, 15, 0, 0, 0, 0, 0);
    assertCount++;
    if (sbIf.stall !== 1'b0 || sbIf.issue_fire !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL pc_issue: got stall=%0b fire=%0b expected 0/1",
               sbIf.stall, sbIf.issue_fire);
    end
    clockEdge();
    assertCount++;
    if (sbIf.pending_mask !== 15'h0000) begin
      failCount++;
      $display("[TB] FAIL pc_mask: got %h expected 0000", sbIf.pending_mask);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 15);
    clockEdge();
    assertCount++;
    if (sbIf.err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL pc_wb_err: got %0b expected 0", sbIf.err);
    end
  endtask

  task automatic test_underflow_async_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
    clockEdge();
    assertCount++;
    if (sbIf.err !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL underflow_err: got %0b expected 1", sbIf.err);
    end
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0);
    clockEdge();
    assertCount++;
    if (sbIf.err !== 1'b1 || sbIf.pending_mask !== 15'h0002) begin
      failCount++;
      $display("[TB] FAIL err_sticky: got err=%0b mask=%h expected 1/0002",
               sbIf.err, sbIf.pending_mask);
    end
    idle();
    rst = 1'b1;
    #1;
    assertCount++;
    if (sbIf.err !== 1'b0 || sbIf.pending_mask !== '0 || sbIf.busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got err=%0b mask=%h busy=%0b expected 0/0000/0",
               sbIf.err, sbIf.pending_mask, sbIf.busy);
    end
    rst = 1'b0;
    modelReset();
    clockEdge();
  endtask

  task automatic test_random();
    int pend [$];
    bit we;
    int wd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pend.delete();
      for (int r = 0; r < NREG; r++) if (mCnt[r] != 0) pend.push_back(r);
      we = ($urandom_range(0, 1) == 1);
      if (pend.size() > 0 && $urandom_range(0, 9) < 8)
        wd = pend[$urandom_range(0, pend.size() - 1)];
      else
        wd = $urandom_range(0, 15);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0, we, wd);
      assertCount++;
      if (sbIf.stall !== expStall || sbIf.issue_fire !== expFire) begin
        failCount++;
        $display("[TB] FAIL rand_comb cyc %0d: got stall=%0b fire=%0b expected %0b/%0b",
                 cyc, sbIf.stall, sbIf.issue_fire, expStall, expFire);
      end
      clockEdge();
      assertCount++;
      if (sbIf.pending_mask !== expMask() || sbIf.busy !== (expMask() != '0) ||
          sbIf.err !== mErr) begin
        failCount++;
        $display("[TB] FAIL rand_state cyc %0d: got mask=%h busy=%0b err=%0b expected %h/%0b/%0b",
                 cyc, sbIf.pending_mask, sbIf.busy, sbIf.err, expMask(),
                 expMask() != '0, mErr);
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_raw();
    test_same_cycle();
    test_flush();
    test_pc();
    test_underflow_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
